// File: rtl/fmem_pkg.sv
// fmem_pkg: shared types and constants for the frame memory write path
// Contents: capture state enum, pixel lanes per memory word, lane index type.
package fmem_pkg;
    typedef enum logic {IDLE, CAPTURE} state_t;
    localparam int LANES = 4;
    typedef logic [$clog2(LANES)-1:0] lane_idx_t;
endpackage

// File: rtl/fmem_pixel_packer.sv
// fmem_pixel_packer: gathers pixels into a LANES-wide word, zero-padded on flush
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push      pixel valid, data goes into the current lane
//   flush     emit the partial word if any lane is filled
//   data      pixel
//   emit      word is complete (combinational, same cycle as push/flush)
//   word      packed word, lane 0 in the low bits
module fmem_pixel_packer
    import fmem_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        flush,
    input  logic [DATA_WIDTH-1:0]       data,
    output logic                        emit,
    output logic [DATA_WIDTH*LANES-1:0] word
);
    logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d;
    lane_idx_t idx_q;

    always_comb begin
        lanes_d = lanes_q;
        if (push) lanes_d[idx_q] = data;
    end

    assign emit = (push && idx_q == lane_idx_t'(LANES - 1)) || (flush && idx_q != '0);
    assign word = lanes_d;

    // lanes are cleared on every emit, so unfilled lanes of a flushed word read as zero
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (emit) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (push) begin
            lanes_q <= lanes_d;
            idx_q   <= idx_q + 1'b1;
        end
endmodule

// File: rtl/fmem_write_packer.sv
// fmem_write_packer: packs a pixel stream into memory words and issues sequential writes
// Ports:
//   i_clk, rst      clock and asynchronous active-high reset
//   i_wr_en         capture enable, sampled on vsync rise
//   i_vsync         frame sync, rising edge starts/ends a frame
//   i_de, i_data    pixel valid and pixel
//   i_hres, i_vres  expected frame geometry (size check only)
//   o_wen, o_waddr, o_wdata  registered memory write
//   o_busy          capturing
//   o_frame_done    one-cycle pulse after a capture frame ends
//   o_overflow      sticky, a write was dropped past ADDR_DEPTH
//   o_size_err      sticky geometry mismatch
// Build option: FMEM_WR_SIZE_CHECK_EN enables the line/frame size check; otherwise o_size_err is 0.
module fmem_write_packer
    import fmem_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int MEM_WIDTH  = DATA_WIDTH * LANES,
    parameter int ADDR_DEPTH = 512 * 512 / 4,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic                  i_vsync,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [10:0]           i_hres,
    input  logic [10:0]           i_vres,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [MEM_WIDTH-1:0]  o_wdata,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_overflow,
    output logic                  o_size_err
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

    state_t state_q, state_d;
    logic vsync_q, de_q;
    logic [ADDR_WIDTH:0] cnt_q;
    logic emit;
    logic [MEM_WIDTH-1:0] word;

    wire capture = state_q == CAPTURE;
    wire vs_rise = i_vsync && !vsync_q;
    wire de_fall = !i_de && de_q;
    wire start   = vs_rise && i_wr_en;
    // pixels on the vsync-rise cycle belong to no frame
    wire push    = capture && i_de && !vs_rise;
    wire flush   = capture && (vs_rise || de_fall);
    wire full    = cnt_q == FULL;

    fmem_pixel_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
        .clk  (i_clk),
        .rst  (rst),
        .push (push),
        .flush(flush),
        .data (i_data),
        .emit (emit),
        .word (word)
    );

    always_comb state_d = vs_rise ? (i_wr_en ? CAPTURE : IDLE) : state_q;

    always_ff @(posedge i_clk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;

    assign o_busy = capture;

    // a flush on the vsync-rise cycle still uses the old address; the counter restarts behind it
    always_ff @(posedge i_clk or posedge rst)
        if (rst) begin
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            cnt_q        <= '0;
            o_wen        <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            vsync_q      <= i_vsync;
            de_q         <= i_de;
            o_frame_done <= vs_rise && capture;
            o_wen        <= emit && !full;
            if (emit && !full) begin
                o_waddr <= cnt_q[ADDR_WIDTH-1:0];
                o_wdata <= word;
            end
            if (vs_rise) cnt_q <= '0;
            else if (emit && !full) cnt_q <= cnt_q + 1'b1;
            // an overflow from the closing frame's flush outlives the restart
            if (start) o_overflow <= 1'b0;
            if (emit && full) o_overflow <= 1'b1;
        end

`ifdef FMEM_WR_SIZE_CHECK_EN
    logic [11:0] pix_q, line_q;

    always_ff @(posedge i_clk or posedge rst)
        if (rst) begin
            pix_q      <= '0;
            line_q     <= '0;
            o_size_err <= 1'b0;
        end else begin
            if (start || de_fall) pix_q <= '0;
            else if (push) pix_q <= pix_q + 1'b1;
            if (start) line_q <= '0;
            else if (capture && de_fall) line_q <= line_q + 1'b1;
            // errors found at the end of a frame stay visible across its restart
            if (start) o_size_err <= 1'b0;
            if (capture && de_fall && pix_q != {1'b0, i_hres}) o_size_err <= 1'b1;
            if (capture && vs_rise && line_q != {1'b0, i_vres}) o_size_err <= 1'b1;
        end
`else
    logic unused_size;
    assign unused_size = ^{i_hres, i_vres};
    assign o_size_err  = 1'b0;
`endif
endmodule

// File: tb/tb_fmem_write_packer.sv
// tb_fmem_write_packer: directed self-checking bench for fmem_write_packer
// Two instances share the stimulus: d with default depth, s with ADDR_DEPTH=4 for overflow.
module tb_fmem_write_packer;
    logic        i_clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_wr_en = 1'b0;
    logic        i_vsync = 1'b0;
    logic        i_de = 1'b0;
    logic [23:0] i_data = '0;
    logic [10:0] i_hres = 11'd6;
    logic [10:0] i_vres = 11'd2;

    logic        d_wen, d_busy, d_done, d_ovf, d_serr;
    logic [15:0] d_waddr;
    logic [95:0] d_wdata;
    logic        s_wen, s_busy, s_done, s_ovf, s_serr;
    logic [1:0]  s_waddr;
    logic [95:0] s_wdata;

    int checks = 0;
    int failures = 0;

    logic [15:0] d_addr_q[$];
    logic [95:0] d_data_q[$];
    logic [1:0]  s_addr_q[$];
    logic [95:0] s_data_q[$];

    localparam logic [95:0] W4321 = 96'h000004_000003_000002_000001;
    localparam logic [95:0] W65   = 96'h000000_000000_000006_000005;
    localparam logic [95:0] WBA   = 96'h000000_000000_00000b_00000a;
    localparam logic [95:0] W8765 = 96'h000008_000007_000006_000005;
`ifdef FMEM_WR_SIZE_CHECK_EN
    localparam logic SERR_EXP = 1'b1;
`else
    localparam logic SERR_EXP = 1'b0;
`endif

    fmem_write_packer d (
        .i_clk(i_clk), .rst(rst), .i_wr_en(i_wr_en), .i_vsync(i_vsync), .i_de(i_de),
        .i_data(i_data), .i_hres(i_hres), .i_vres(i_vres), .o_wen(d_wen), .o_waddr(d_waddr),
        .o_wdata(d_wdata), .o_busy(d_busy), .o_frame_done(d_done), .o_overflow(d_ovf),
        .o_size_err(d_serr)
    );

    fmem_write_packer #(.ADDR_DEPTH(4)) s (
        .i_clk(i_clk), .rst(rst), .i_wr_en(i_wr_en), .i_vsync(i_vsync), .i_de(i_de),
        .i_data(i_data), .i_hres(i_hres), .i_vres(i_vres), .o_wen(s_wen), .o_waddr(s_waddr),
        .o_wdata(s_wdata), .o_busy(s_busy), .o_frame_done(s_done), .o_overflow(s_ovf),
        .o_size_err(s_serr)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (d_wen) begin
            d_addr_q.push_back(d_waddr);
            d_data_q.push_back(d_wdata);
        end
        if (s_wen) begin
            s_addr_q.push_back(s_waddr);
            s_data_q.push_back(s_wdata);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        d_addr_q = {};
        d_data_q = {};
        s_addr_q = {};
        s_data_q = {};
    endtask

    task automatic frame_start(input logic en);
        i_wr_en = en;
        i_vsync = 1'b1;
        tick();
        i_vsync = 1'b0;
    endtask

    task automatic send_line(input int n, input int base);
        for (int p = 0; p < n; p++) begin
            i_de = 1'b1;
            i_data = 24'(base + p);
            tick();
        end
        i_de = 1'b0;
        i_data = '0;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_wen", d_wen, 0);
        chk("rst_waddr", d_waddr, 0);
        chk("rst_wdata", d_wdata, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_done", d_done, 0);
        chk("rst_ovf", d_ovf, 0);
        chk("rst_serr", d_serr, 0);
        rst = 1'b0;
        tick();

        frame_start(1'b1);
        chk("t1_busy", d_busy, 1);
        for (int p = 1; p <= 4; p++) begin
            i_de = 1'b1;
            i_data = 24'(p);
            tick();
            if (p < 4) chk("t1_wen_early", d_wen, 0);
        end
        chk("t1_wen", d_wen, 1);
        chk("t1_waddr", d_waddr, 0);
        chk("t1_wdata", d_wdata, W4321);
        i_de = 1'b0;
        tick();
        chk("t1_wen_off", d_wen, 0);

        frame_start(1'b1);
        chk("t2_done", d_done, 1);
        chk("t2_busy", d_busy, 1);
        clear_q();
        send_line(6, 1);
        send_line(6, 1);
        chk("t2_count", d_addr_q.size(), 4);
        chk("t2_a0", d_addr_q[0], 0);
        chk("t2_d0", d_data_q[0], W4321);
        chk("t2_a1", d_addr_q[1], 1);
        chk("t2_d1", d_data_q[1], W65);
        chk("t2_a2", d_addr_q[2], 2);
        chk("t2_d2", d_data_q[2], W4321);
        chk("t2_a3", d_addr_q[3], 3);
        chk("t2_d3", d_data_q[3], W65);
        chk("t2_s_count", s_addr_q.size(), 4);
        chk("t2_s_ovf", s_ovf, 0);

        frame_start(1'b1);
        clear_q();
        send_line(20, 1);
        chk("t3_s_count", s_addr_q.size(), 4);
        chk("t3_s_a0", s_addr_q[0], 0);
        chk("t3_s_a3", s_addr_q[3], 3);
        chk("t3_s_ovf", s_ovf, 1);
        chk("t3_d_count", d_addr_q.size(), 5);
        chk("t3_d_a4", d_addr_q[4], 4);
        chk("t3_d_ovf", d_ovf, 0);
        repeat (5) tick();
        chk("t3_s_ovf_sticky", s_ovf, 1);

        frame_start(1'b1);
        chk("t4_s_ovf_clr", s_ovf, 0);
        clear_q();
        i_de = 1'b1;
        i_data = 24'hA;
        tick();
        i_data = 24'hB;
        tick();
        i_wr_en = 1'b0;
        i_vsync = 1'b1;
        i_data = 24'hC;
        tick();
        i_vsync = 1'b0;
        chk("t4_wen", d_wen, 1);
        chk("t4_waddr", d_waddr, 0);
        chk("t4_wdata", d_wdata, WBA);
        chk("t4_done", d_done, 1);
        chk("t4_busy", d_busy, 0);
        for (int p = 0; p < 5; p++) begin
            i_data = 24'(16 + p);
            tick();
        end
        i_de = 1'b0;
        tick();
        tick();
        chk("t4_done_off", d_done, 0);
        chk("t4_count", d_addr_q.size(), 1);

        i_de = 1'b0;
        frame_start(1'b1);
        clear_q();
        i_de = 1'b1;
        i_data = 24'h1;
        tick();
        i_data = 24'h2;
        tick();
        i_de = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_wen", d_wen, 0);
        chk("t5_waddr", d_waddr, 0);
        chk("t5_wdata", d_wdata, 0);
        chk("t5_busy", d_busy, 0);
        chk("t5_done", d_done, 0);
        chk("t5_s_ovf", s_ovf, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_noflush", d_addr_q.size(), 0);
        frame_start(1'b1);
        for (int p = 5; p <= 8; p++) begin
            i_de = 1'b1;
            i_data = 24'(p);
            tick();
        end
        i_de = 1'b0;
        chk("t5_wen2", d_wen, 1);
        chk("t5_waddr2", d_waddr, 0);
        chk("t5_wdata2", d_wdata, W8765);
        tick();
        chk("t5_count", d_addr_q.size(), 1);

        frame_start(1'b1);
        send_line(5, 1);
        frame_start(1'b0);
        tick();
        chk("t6_serr", d_serr, SERR_EXP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fmem_write_packer.md
# fmem_write_packer

Write-side stage of the frame memory path. Accepts a pixel stream (one DATA_WIDTH pixel per cycle under data-enable), packs four pixels into one MEM_WIDTH word and issues sequential single-cycle writes to the frame memory, which the read controller then scans out. Frame capture is armed per frame and restarts at address 0 on every vsync rising edge.

## Interface
- DATA_WIDTH, 24, bits per pixel
- MEM_WIDTH, DATA_WIDTH*4, memory word width (four pixel lanes)
- ADDR_DEPTH, 512*512/4, memory depth in words
- ADDR_WIDTH, $clog2(ADDR_DEPTH), write address width
- i_clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- i_wr_en  in  1  capture enable, sampled only on vsync rising edge
- i_vsync  in  1  frame sync, rising edge = frame start
- i_de  in  1  pixel valid
- i_data  in  DATA_WIDTH  pixel
- i_hres  in  11  active pixels per line (used by size check only)
- i_vres  in  11  active lines per frame (used by size check only)
- o_wen  out  1  memory write strobe, one cycle per word
- o_waddr  out  ADDR_WIDTH  write address
- o_wdata  out  MEM_WIDTH  packed word, lane 0 in bits [DATA_WIDTH-1:0]
- o_busy  out  1  high in CAPTURE
- o_frame_done  out  1  one-cycle pulse when a capture frame ends
- o_overflow  out  1  sticky, write dropped past ADDR_DEPTH
- o_size_err  out  1  sticky, only with the size-check macro (tied 0 otherwise)

## Operation
- States: IDLE, CAPTURE.
- IDLE: i_de ignored. vsync rise with i_wr_en=1 -> CAPTURE; word counter, lane index cleared; o_overflow, o_size_err cleared.
- CAPTURE: each i_de=1 cycle writes i_data into lane[lane_idx], lane_idx increments mod 4. Completion of lane 3 -> write of the packed word.
- Line end (i_de 1->0) with lane_idx!=0: partial word flushed, unfilled lanes zero; lane_idx -> 0. Each line therefore starts on a fresh word; words per line = ceil(pixels/4).
- vsync rise in CAPTURE: pending partial word flushed at current address; o_frame_done pulses; i_wr_en=1 -> restart CAPTURE at address 0 (same cycle), else -> IDLE. i_de on the vsync-rise cycle is ignored.
- Word counter is ADDR_WIDTH+1 bits; write with counter == ADDR_DEPTH is suppressed (o_wen stays 0), o_overflow set; counter saturates.
- Write address = counter of the issuing word; counter increments after each issued write.

## Timing
- o_wen/o_waddr/o_wdata registered: valid the cycle after the 4th pixel (or the de-fall / vsync-rise cycle for a flush).
- Back-to-back full words possible every 4 cycles; flush and next-line lane 0 never collide (de low at least one cycle between lines).
- o_frame_done: cycle after vsync rise.
- Reset: state IDLE, all outputs 0, lane buffer and counters 0. Reset mid-frame discards partial word, no write issued.

## Configuration
- FMEM_WR_SIZE_CHECK_EN defined: per-line pixel counter and per-frame line counter; line length != i_hres or, at frame end, line count != i_vres sets o_size_err (sticky until next capture start).
- Undefined: counters absent, o_size_err constant 0.

## Structure
- Shared package fmem_pkg: state enum (IDLE, CAPTURE), LANES=4 constant, lane index type.
- One sub-module natural: fmem_pixel_packer (lane buffer, lane index, flush/zero padding); top holds FSM, address counter, overflow and size check.

## Test plan
- vsync rise, i_wr_en=1, pixels 0x000001..0x000004 -> one cycle later o_wen=1, o_waddr=0, o_wdata=0x000004_000003_000002_000001.
- i_hres=6, two lines of 1..6 -> words at addr 0 {4,3,2,1}, addr 1 {0,0,6,5}, addr 2 {4,3,2,1}, addr 3 {0,0,6,5}.
- ADDR_DEPTH=4, 20 pixels -> 4 writes addr 0..3, 5th suppressed, o_overflow=1 until next capture start.
- vsync rise with lane_idx=2 and i_wr_en=0 -> flush at current addr, o_frame_done pulse, o_busy 0, later de ignored.
- rst asserted after 2 pixels -> no write, all outputs 0; next frame starts at addr 0.
- With FMEM_WR_SIZE_CHECK_EN, i_hres=6, a 5-pixel line -> o_size_err=1; without macro stays 0.
